// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, latches operands, registers the result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [2:0]  r0_sel,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [2:0]  r1_sel,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_sf,
  output logic        rsp_zf,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_sf,
  input  logic        alu_zf,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [31:0] lat_a;
  logic [31:0] lat_b;
  logic [2:0]  lat_sel;
  logic        gid;
  logic        gnt;
  logic        accept;
  logic        rsp_done;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = ~r0_valid;
  end
`else
  logic last_grant;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt = ~r0_valid;
    if (r0_valid && r1_valid)
      gnt = ~last_grant;
  end
`endif

  always_comb begin
    accept   = (state == IDLE) && (r0_valid || r1_valid) && !rst;
    r0_ready = accept && !gnt;
    r1_ready = accept && gnt;
    rsp_done = gid ? rsp1_ready : rsp0_ready;
  end

  assign rsp0_valid = (state == RESP) && !gid;
  assign rsp1_valid = (state == RESP) && gid;
  assign busy       = (state != IDLE);
  assign alu_a      = lat_a;
  assign alu_b      = lat_b;
  assign alu_sel    = lat_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_a    <= '0;
      lat_b    <= '0;
      lat_sel  <= '0;
      gid      <= 1'b0;
      rsp_data <= '0;
      rsp_sf   <= 1'b0;
      rsp_zf   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_a   <= gnt ? r1_a   : r0_a;
            lat_b   <= gnt ? r1_b   : r0_b;
            lat_sel <= gnt ? r1_sel : r0_sel;
            gid     <= gnt;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= gnt;
`endif
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data <= alu_out;
          rsp_sf   <= alu_sf;
          rsp_zf   <= alu_zf;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
